// File: rtl/cpu_int_seq.sv
// cpu_int_seq -- interrupt and reset sequencer for the 6502 core.
//
// At instruction boundaries it chooses between reset, NMI, BRK and IRQ. It then
// takes over the bus for one six-cycle sequence: push PCH, PCL and P, fetch the
// 16-bit vector, and load PC. During a reset sequence the pushes are dummy reads
// (no write strobe), but SP still moves down by three.
//
// Configuration macro:
//   CPU_INT_NMI_HIJACK_EN  defined:   a pending NMI seen at VEC_LO redirects an
//                                     IRQ/BRK sequence to NMI_VEC and consumes it.
//                          undefined: the source chosen at take fixes the vector.
//                                     A pending NMI waits for the next boundary.
//
// Ports:
//   clk, reset         CPU clock; asynchronous active-high reset
//   nmi_n              NMI request, active on a falling edge
//   irq_n              IRQ request, active-low level, sampled at take only
//   brk_req            BRK retired, qualified by instruction_done
//   instruction_done   current instruction retires this cycle
//   i_flag             status I bit (IRQ mask)
//   pc_in/sp_in/status_in  CPU state latched at take
//   mem_din            read data, one cycle after its address
//   busy               sequencer owns the bus (includes the take cycle)
//   addr_out/addr_valid, mem_we, dout   bus master outputs
//   sp_dec             decrement SP this cycle
//   pc_load/pc_value   load PC with the fetched vector
//   set_i              set the I flag this cycle
module cpu_int_seq #(
  parameter logic [15:0] STACK_BASE = 16'h0100,
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] RST_VEC    = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instruction_done,
  input  logic        i_flag,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  status_in,
  input  logic [7:0]  mem_din,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        addr_valid,
  output logic        mem_we,
  output logic [7:0]  dout,
  output logic        sp_dec,
  output logic        pc_load,
  output logic [15:0] pc_value,
  output logic        set_i
);

  typedef enum logic [2:0] {
    IDLE, RST_PEND, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC
  } state_e;

  typedef enum logic [1:0] {SRC_RST, SRC_NMI, SRC_BRK, SRC_IRQ} src_e;

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  st_q, st_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  lo_q, lo_d;
  logic        nmi_s_q;
  logic        nmi_pend_q, nmi_pend_d;

  logic        take;
  logic        nmi_fall;
  logic        use_nmi_vec;
  logic        consume;
  logic [15:0] vec_sel;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_PEND;
      src_q      <= SRC_RST;
      pc_q       <= '0;
      sp_q       <= '0;
      st_q       <= '0;
      vec_q      <= '0;
      lo_q       <= '0;
      nmi_s_q    <= 1'b1;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      pc_q       <= pc_d;
      sp_q       <= sp_d;
      st_q       <= st_d;
      vec_q      <= vec_d;
      lo_q       <= lo_d;
      nmi_s_q    <= nmi_n;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  // The fall is detected against the registered sample. The pending bit is
  // therefore visible one cycle after the edge and never on the edge cycle.
  assign nmi_fall = nmi_s_q & ~nmi_n;

  assign take = (state_q == IDLE) && instruction_done &&
                (nmi_pend_q || brk_req || (!irq_n && !i_flag));

`ifdef CPU_INT_NMI_HIJACK_EN
  // Any pending NMI wins the vector at VEC_LO, except during a reset sequence.
  assign use_nmi_vec = nmi_pend_q && (src_q != SRC_RST);
`else
  assign use_nmi_vec = (src_q == SRC_NMI);
`endif

  assign vec_sel = use_nmi_vec         ? NMI_VEC :
                   (src_q == SRC_RST)  ? RST_VEC : IRQ_VEC;
  assign consume = (state_q == VEC_LO) && use_nmi_vec;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    st_d       = st_q;
    vec_d      = vec_q;
    lo_d       = lo_q;
    // A new edge in the consuming cycle re-arms the request, so it is not lost.
    nmi_pend_d = (nmi_pend_q & ~consume) | nmi_fall;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = PUSH_PCH;
          src_d   = brk_req ? SRC_BRK : (nmi_pend_q ? SRC_NMI : SRC_IRQ);
          pc_d    = pc_in;
          sp_d    = sp_in;
          st_d    = status_in;
        end
      end
      RST_PEND: begin
        state_d = PUSH_PCH;
        src_d   = SRC_RST;
        pc_d    = pc_in;
        sp_d    = sp_in;
        st_d    = status_in;
      end
      PUSH_PCH: begin
        state_d = PUSH_PCL;
        sp_d    = sp_q - 8'd1;
      end
      PUSH_PCL: begin
        state_d = PUSH_P;
        sp_d    = sp_q - 8'd1;
      end
      PUSH_P: begin
        state_d = VEC_LO;
        sp_d    = sp_q - 8'd1;
      end
      VEC_LO: begin
        state_d = VEC_HI;
        vec_d   = vec_sel;
      end
      VEC_HI: begin
        state_d = LOAD_PC;
        lo_d    = mem_din;
      end
      LOAD_PC: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != IDLE) | take;
    addr_out   = '0;
    addr_valid = 1'b0;
    mem_we     = 1'b0;
    dout       = '0;
    sp_dec     = 1'b0;
    pc_load    = 1'b0;
    pc_value   = '0;
    set_i      = 1'b0;

    unique case (state_q)
      PUSH_PCH, PUSH_PCL, PUSH_P: begin
        addr_out   = STACK_BASE + {8'h00, sp_q};
        addr_valid = 1'b1;
        mem_we     = (src_q != SRC_RST);
        sp_dec     = 1'b1;
        if (state_q == PUSH_PCH)      dout = pc_q[15:8];
        else if (state_q == PUSH_PCL) dout = pc_q[7:0];
        else dout = {st_q[7:6], 1'b1, (src_q == SRC_BRK), st_q[3:0]};
      end
      VEC_LO: begin
        addr_out   = vec_sel;
        addr_valid = 1'b1;
        set_i      = 1'b1;
      end
      VEC_HI: begin
        addr_out   = vec_q + 16'd1;
        addr_valid = 1'b1;
      end
      LOAD_PC: begin
        pc_load  = 1'b1;
        pc_value = {mem_din, lo_q};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_int_seq.sv
// Testbench for cpu_int_seq: directed steps plus randomized boundaries, checked
// against a transaction-level model of the push/vector/load sequence.
module tb_cpu_int_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        nmi_n = 1'b1;
  logic        irq_n = 1'b1;
  logic        brk_req = 1'b0;
  logic        instruction_done = 1'b0;
  logic        i_flag = 1'b0;
  logic [15:0] pc_in = '0;
  logic [7:0]  sp_in = '0;
  logic [7:0]  status_in = '0;
  logic [7:0]  mem_din = '0;
  logic        busy, addr_valid, mem_we, sp_dec, pc_load, set_i;
  logic [15:0] addr_out, pc_value;
  logic [7:0]  dout;

  int ntests = 0;
  int nfail  = 0;
  logic [7:0] vmem [0:5];
  bit model_pend = 1'b0;

  cpu_int_seq #(
    .STACK_BASE(16'h0100), .NMI_VEC(16'hFFFA), .RST_VEC(16'hFFFC), .IRQ_VEC(16'hFFFE)
  ) dut (
    .clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n), .brk_req(brk_req),
    .instruction_done(instruction_done), .i_flag(i_flag), .pc_in(pc_in),
    .sp_in(sp_in), .status_in(status_in), .mem_din(mem_din), .busy(busy),
    .addr_out(addr_out), .addr_valid(addr_valid), .mem_we(mem_we), .dout(dout),
    .sp_dec(sp_dec), .pc_load(pc_load), .pc_value(pc_value), .set_i(set_i)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [15:0] a);
    if (a >= 16'hFFFA) return vmem[int'(a - 16'hFFFA)];
    return a[7:0] ^ a[15:8];
  endfunction

  // Synchronous memory: data valid the cycle after its address.
  always @(posedge clk) mem_din <= rd(addr_out);

  function automatic logic [63:0] pk(input bit b, input bit av, input logic [15:0] a,
                                     input bit we, input logic [7:0] d, input bit spd,
                                     input bit si, input bit pl, input logic [15:0] pv);
    return {18'd0, b, av, a, we, d, spd, si, pl, pv};
  endfunction

  function automatic logic [63:0] bus_obs();
    return pk(busy, addr_valid, addr_out, mem_we, dout, sp_dec, set_i, pc_load, pc_value);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks one full sequence cycle by cycle, starting at the negedge in PUSH_PCH.
  task automatic run_seq(input string name, input bit is_rst, input bit is_brk,
                         input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] st,
                         input logic [15:0] vec, input int nmi_fall_k);
    logic [7:0]  pbyte = {st[7:6], 1'b1, is_brk, st[3:0]};
    logic [7:0]  sp1 = sp - 8'd1;
    logic [7:0]  sp2 = sp - 8'd2;
    logic [15:0] vec1 = vec + 16'd1;
    logic [15:0] newpc = {rd(vec1), rd(vec)};
    logic [63:0] e;
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: e = pk(1, 1, {8'h01, sp},  !is_rst, pc[15:8], 1, 0, 0, 16'h0);
        1: e = pk(1, 1, {8'h01, sp1}, !is_rst, pc[7:0],  1, 0, 0, 16'h0);
        2: e = pk(1, 1, {8'h01, sp2}, !is_rst, pbyte,    1, 0, 0, 16'h0);
        3: e = pk(1, 1, vec,  0, 8'h0, 0, 1, 0, 16'h0);
        4: e = pk(1, 1, vec1, 0, 8'h0, 0, 0, 0, 16'h0);
        default: e = pk(1, 0, 16'h0, 0, 8'h0, 0, 0, 1, newpc);
      endcase
      chk($sformatf("%s.cyc%0d", name, k), bus_obs(), e);
      if (k == nmi_fall_k) nmi_n = 1'b0;
      else nmi_n = 1'b1;
      @(negedge clk);
    end
    chk($sformatf("%s.done", name), bus_obs(), 64'h0);
  endtask

  // One instruction boundary; leaves time at the negedge after it (+1).
  task automatic boundary(input string name, input bit brk, input bit irq, input bit ifl,
                          input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] st,
                          input bit exp_take);
    @(negedge clk);
    instruction_done = 1'b1; brk_req = brk; irq_n = !irq; i_flag = ifl;
    pc_in = pc; sp_in = sp; status_in = st;
    #1 chk($sformatf("%s.take", name), {62'd0, busy, addr_valid}, {62'd0, exp_take, 1'b0});
    @(negedge clk);
    instruction_done = 1'b0; brk_req = 1'b0; irq_n = 1'b1;
    pc_in = 16'($urandom); sp_in = 8'($urandom); status_in = 8'($urandom);
    #1 if (!exp_take) chk($sformatf("%s.quiet", name), bus_obs(), 64'h0);
  endtask

  task automatic nmi_edge();
    @(negedge clk) nmi_n = 1'b0;
    @(negedge clk) nmi_n = 1'b1;
  endtask

  logic [15:0] r_pc, r_vec;
  logic [7:0]  r_sp, r_st;
  bit r_brk, r_irq, r_ifl, r_nmi, r_take, r_use_nmi;

  initial begin
    vmem[0] = 8'h00; vmem[1] = 8'h90; vmem[2] = 8'h34;
    vmem[3] = 8'h12; vmem[4] = 8'h56; vmem[5] = 8'hA4;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", bus_obs(), pk(1, 0, 16'h0, 0, 8'h0, 0, 0, 0, 16'h0));

    // Reset release: dummy pushes at 01FD..01FB, vector FFFC -> PC 1234.
    sp_in = 8'hFD; pc_in = 16'hBEEF; status_in = 8'h04;
    reset = 1'b0;
    @(negedge clk);
    run_seq("rst", 1, 0, 16'hBEEF, 8'hFD, 8'h04, 16'hFFFC, -1);

    // IRQ taken.
    boundary("irq", 0, 1, 0, 16'hC123, 8'hFF, 8'h01, 1);
    run_seq("irq", 0, 0, 16'hC123, 8'hFF, 8'h01, 16'hFFFE, -1);

    // IRQ masked by I.
    boundary("irq_masked", 0, 1, 1, 16'h4444, 8'hFF, 8'h04, 0);

    // BRK with SP wrap.
    boundary("brk", 1, 0, 0, 16'h2345, 8'h01, 8'h00, 1);
    run_seq("brk", 0, 1, 16'h2345, 8'h01, 8'h00, 16'hFFFE, -1);

    // NMI falling during PUSH_PCL of a BRK sequence.
    boundary("hijack", 1, 0, 0, 16'h8001, 8'hF0, 8'h81, 1);
`ifdef CPU_INT_NMI_HIJACK_EN
    run_seq("hijack", 0, 1, 16'h8001, 8'hF0, 8'h81, 16'hFFFA, 1);
    boundary("nmi_consumed", 0, 0, 0, 16'h9000, 8'hED, 8'h00, 0);
`else
    run_seq("hijack", 0, 1, 16'h8001, 8'hF0, 8'h81, 16'hFFFE, 1);
    boundary("nmi_next", 0, 0, 0, 16'h9000, 8'hED, 8'h00, 1);
    run_seq("nmi_next", 0, 0, 16'h9000, 8'hED, 8'h00, 16'hFFFA, -1);
    boundary("nmi_consumed", 0, 0, 0, 16'h9100, 8'hEA, 8'h00, 0);
`endif

    // Reset during VEC_HI of an IRQ sequence.
    boundary("irq_abort", 0, 1, 0, 16'h7777, 8'hC0, 8'h00, 1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_reset_vals", bus_obs(), pk(1, 0, 16'h0, 0, 8'h0, 0, 0, 0, 16'h0));
    @(negedge clk);
    sp_in = 8'h42; pc_in = 16'h0F0F; status_in = 8'h00;
    reset = 1'b0;
    @(negedge clk);
    run_seq("rst2", 1, 0, 16'h0F0F, 8'h42, 8'h00, 16'hFFFC, -1);
    model_pend = 1'b0;

    // Randomized boundaries against the transaction model.
    for (int it = 0; it < 40; it++) begin
      for (int v = 0; v < 6; v++) vmem[v] = 8'($urandom);
      r_brk = ($urandom_range(0, 3) == 0);
      r_irq = 1'($urandom_range(0, 1));
      r_ifl = 1'($urandom_range(0, 1));
      r_nmi = ($urandom_range(0, 3) == 0);
      r_pc  = 16'($urandom); r_sp = 8'($urandom); r_st = 8'($urandom);
      if (r_nmi) begin
        nmi_edge();
        model_pend = 1'b1;
      end
      r_take = model_pend || r_brk || (r_irq && !r_ifl);
      boundary($sformatf("rnd%0d", it), r_brk, r_irq, r_ifl, r_pc, r_sp, r_st, r_take);
      if (r_take) begin
`ifdef CPU_INT_NMI_HIJACK_EN
        r_use_nmi = model_pend;
`else
        r_use_nmi = !r_brk && model_pend;
`endif
        r_vec = r_use_nmi ? 16'hFFFA : 16'hFFFE;
        if (r_use_nmi) model_pend = 1'b0;
        run_seq($sformatf("rnd%0d", it), 0, r_brk, r_pc, r_sp, r_st, r_vec, -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
